// File: rtl/config_shift_loader_if.sv
// Serial configuration stream and block-load bus between a bitstream source
// and config_shift_loader.
interface config_shift_loader_if #(
  parameter int MEM_SIZE   = 16,
  parameter int NUM_BLOCKS = 4
);
  logic                  start;
  logic                  bit_in;
  logic                  bit_valid;
  logic                  bit_ready;
  logic [MEM_SIZE-1:0]   config_out;
  logic [NUM_BLOCKS-1:0] cen;
  logic                  busy;
  logic                  done;

  modport master (
    output start, bit_in, bit_valid,
    input  bit_ready, config_out, cen, busy, done
  );

  modport slave (
    input  start, bit_in, bit_valid,
    output bit_ready, config_out, cen, busy, done
  );
endinterface

// File: rtl/config_shift_loader.sv
// Serial front end that assembles MEM_SIZE-bit words and loads them one per
// downstream latch block, in block order, with a single-cycle one-hot enable.
module config_shift_loader #(
  parameter int MEM_SIZE   = 16,
  parameter int NUM_BLOCKS = 4
) (
  input logic                  cclk,
  input logic                  crst_n,
  config_shift_loader_if.slave cfg
);

  localparam int CNT_W = $clog2(MEM_SIZE + 1);
  localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(MEM_SIZE - 1);
  localparam logic [IDX_W-1:0]      LAST_BLK = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [NUM_BLOCKS-1:0] CEN_ONE  = NUM_BLOCKS'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_r;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic [IDX_W-1:0]      block_idx_r;
  logic [MEM_SIZE-1:0]   config_r;
  logic [NUM_BLOCKS-1:0] cen_r;
  logic                  bit_ready_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  accept_s;

  assign accept_s       = cfg.bit_valid && bit_ready_r;
  assign cfg.bit_ready  = bit_ready_r;
  assign cfg.config_out = config_r;
  assign cfg.cen        = cen_r;
  assign cfg.busy       = busy_r;
  assign cfg.done       = done_r;

  // Sequencer: start has priority in every state; cen defaults low so a pulse
  // never outlasts the single LOAD cycle.
  always_ff @(posedge cclk or negedge crst_n) begin
    if (!crst_n) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= {CNT_W{1'b0}};
      block_idx_r <= {IDX_W{1'b0}};
      config_r    <= {MEM_SIZE{1'b0}};
      cen_r       <= {NUM_BLOCKS{1'b0}};
      bit_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      cen_r <= {NUM_BLOCKS{1'b0}};
      if (cfg.start) begin
        // A bit offered alongside start is dropped; the partial word is kept.
        state_r     <= ST_SHIFT;
        bit_cnt_r   <= {CNT_W{1'b0}};
        block_idx_r <= {IDX_W{1'b0}};
        bit_ready_r <= 1'b1;
        busy_r      <= 1'b1;
        done_r      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_SHIFT: begin
            if (accept_s) begin
              config_r <= {cfg.bit_in, config_r[MEM_SIZE-1:1]};
              if (bit_cnt_r == LAST_BIT) begin
                bit_cnt_r   <= {CNT_W{1'b0}};
                state_r     <= ST_LOAD;
                cen_r       <= CEN_ONE << block_idx_r;
                bit_ready_r <= 1'b0;
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              end
            end else begin
              state_r <= ST_SHIFT;
            end
          end
          ST_LOAD: begin
            if (block_idx_r == LAST_BLK) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              block_idx_r <= block_idx_r + IDX_W'(1);
              state_r     <= ST_SHIFT;
              bit_ready_r <= 1'b1;
            end
          end
          ST_DONE: begin
            state_r <= ST_DONE;
          end
          default: begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= {CNT_W{1'b0}};
            block_idx_r <= {IDX_W{1'b0}};
            bit_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_config_shift_loader.sv
// Directed and randomized bench for config_shift_loader with one single-block
// and one four-block instance, checked against a word/block-order model.
module tb_config_shift_loader;

  logic cclk = 1'b0;
  logic rst1_n;
  logic rst4_n;
  int   checks = 0;
  int   errors = 0;

  // Model of the four-block column: next block to load and current word.
  int          m_blk;
  logic [15:0] m_cfg;

  config_shift_loader_if #(.MEM_SIZE(16), .NUM_BLOCKS(1)) if1 ();
  config_shift_loader_if #(.MEM_SIZE(16), .NUM_BLOCKS(4)) if4 ();

  config_shift_loader #(.MEM_SIZE(16), .NUM_BLOCKS(1)) dut1 (
    .cclk (cclk), .crst_n (rst1_n), .cfg (if1.slave)
  );
  config_shift_loader #(.MEM_SIZE(16), .NUM_BLOCKS(4)) dut4 (
    .cclk (cclk), .crst_n (rst4_n), .cfg (if4.slave)
  );

  always #5 cclk = ~cclk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no summary, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic start4();
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    m_blk = 0;
    chk("start_ready", 32'(if4.bit_ready), 32'h1);
    chk("start_busy",  32'(if4.busy),      32'h1);
    chk("start_done",  32'(if4.done),      32'h0);
  endtask

  // Stream one word LSB-first with random gaps; ends in the LOAD cycle.
  task automatic feed4(input logic [15:0] w, input int maxgap);
    int g;
    for (int i = 0; i < 16; i++) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      if4.bit_valid = 1'b0;
      for (int k = 0; k < g; k++) begin
        if4.bit_in = 1'($urandom);
        tick();
        chk("gap_hold", 32'(if4.config_out), 32'(m_cfg));
      end
      chk("shift_ready", 32'(if4.bit_ready), 32'h1);
      if4.bit_valid = 1'b1;
      if4.bit_in    = w[i];
      tick();
      m_cfg = {w[i], m_cfg[15:1]};
    end
    if4.bit_in = 1'($urandom);
    chk("load_cen",   32'(if4.cen),        32'(4'b0001 << m_blk));
    chk("load_cfg",   32'(if4.config_out), 32'(w));
    chk("load_ready", 32'(if4.bit_ready),  32'h0);
  endtask

  task automatic leave_load4(input logic [15:0] w);
    tick();
    chk("post_load_cfg", 32'(if4.config_out), 32'(w));
    chk("post_load_cen", 32'(if4.cen),        32'h0);
    if (m_blk == 3) begin
      chk("final_done",  32'(if4.done),      32'h1);
      chk("final_ready", 32'(if4.bit_ready), 32'h0);
      chk("final_busy",  32'(if4.busy),      32'h0);
    end else begin
      m_blk++;
      chk("mid_done",  32'(if4.done),      32'h0);
      chk("mid_ready", 32'(if4.bit_ready), 32'h1);
    end
  endtask

  initial begin
    logic [15:0] w1;
    logic [15:0] words [4];
    rst1_n = 1'b0;
    rst4_n = 1'b0;
    if1.start = 1'b0; if1.bit_in = 1'b0; if1.bit_valid = 1'b0;
    if4.start = 1'b0; if4.bit_in = 1'b0; if4.bit_valid = 1'b0;
    m_blk = 0;
    m_cfg = 16'h0000;
    #12;
    chk("rst_ready", 32'(if4.bit_ready),  32'h0);
    chk("rst_cfg",   32'(if4.config_out), 32'h0);
    chk("rst_cen",   32'(if4.cen),        32'h0);
    chk("rst_busy",  32'(if4.busy),       32'h0);
    chk("rst_done",  32'(if4.done),       32'h0);
    chk("rst1_cen",  32'(if1.cen),        32'h0);
    @(negedge cclk);
    rst1_n = 1'b1;
    rst4_n = 1'b1;
    tick();

    // Single block: bits offered in IDLE are ignored, then 0xA5C3.
    if1.bit_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if1.bit_in = ~if1.bit_in;
      tick();
      chk("idle_cfg",   32'(if1.config_out), 32'h0);
      chk("idle_ready", 32'(if1.bit_ready),  32'h0);
    end
    w1 = 16'hA5C3;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("nb1_ready", 32'(if1.bit_ready), 32'h1);
      chk("nb1_nocen", 32'(if1.cen),       32'h0);
      if1.bit_in = w1[i];
      tick();
    end
    chk("nb1_cen",   32'(if1.cen),        32'h1);
    chk("nb1_cfg",   32'(if1.config_out), 32'hA5C3);
    chk("nb1_busy",  32'(if1.busy),       32'h1);
    tick();
    chk("nb1_cen_off", 32'(if1.cen),       32'h0);
    chk("nb1_done",    32'(if1.done),      32'h1);
    chk("nb1_ready0",  32'(if1.bit_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      if1.bit_in = ~if1.bit_in;
      tick();
      chk("done_hold_cfg", 32'(if1.config_out), 32'hA5C3);
      chk("done_hold",     32'(if1.done),       32'h1);
    end
    if1.bit_valid = 1'b0;

    // Four blocks back to back with bit_valid held high.
    words[0] = 16'h0001; words[1] = 16'h8000;
    words[2] = 16'hFFFF; words[3] = 16'h1234;
    start4();
    for (int b = 0; b < 4; b++) begin
      feed4(words[b], 0);
      leave_load4(words[b]);
    end
    for (int i = 0; i < 3; i++) begin
      if4.bit_valid = 1'b1;
      if4.bit_in    = 1'($urandom);
      tick();
      chk("done4_cfg",  32'(if4.config_out), 32'h1234);
      chk("done4_done", 32'(if4.done),       32'h1);
    end

    // Random stalls while loading 0x5A5A into block 0.
    start4();
    feed4(16'h5A5A, 5);
    leave_load4(16'h5A5A);

    // Restart after 7 bits of block 1; the bit offered with start is dropped.
    for (int i = 0; i < 7; i++) begin
      if4.bit_valid = 1'b1;
      if4.bit_in    = 1'($urandom);
      m_cfg = {if4.bit_in, m_cfg[15:1]};
      tick();
    end
    if4.start  = 1'b1;
    if4.bit_in = ~m_cfg[15];
    tick();
    if4.start = 1'b0;
    m_blk = 0;
    chk("restart_cfg",   32'(if4.config_out), 32'(m_cfg));
    chk("restart_ready", 32'(if4.bit_ready),  32'h1);
    chk("restart_cen",   32'(if4.cen),        32'h0);
    feed4(16'h3C96, 2);
    leave_load4(16'h3C96);
    feed4(16'hC3E1, 0);
    leave_load4(16'hC3E1);

    // Reset during the LOAD cycle of block 2.
    feed4(16'h7E81, 1);
    #2;
    rst4_n = 1'b0;
    #1;
    chk("arst_cen",   32'(if4.cen),        32'h0);
    chk("arst_cfg",   32'(if4.config_out), 32'h0);
    chk("arst_ready", 32'(if4.bit_ready),  32'h0);
    chk("arst_busy",  32'(if4.busy),       32'h0);
    chk("arst_done",  32'(if4.done),       32'h0);
    if4.bit_valid = 1'b0;
    m_cfg = 16'h0000;
    @(negedge cclk);
    rst4_n = 1'b1;
    tick();
    chk("arst_idle_ready", 32'(if4.bit_ready), 32'h0);
    start4();
    feed4(16'h0F0F, 0);
    leave_load4(16'h0F0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
